// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter: operation modes and FSM states.
package shift_pkg;

  localparam logic [1:0] MODE_ROR = 2'b00;
  localparam logic [1:0] MODE_LSL = 2'b01;
  localparam logic [1:0] MODE_LSR = 2'b10;
  localparam logic [1:0] MODE_ASR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step of 0..STEP positions, plus the last bit
// pushed out of the word during that step.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic [1:0]       mode_i,
  input  logic [KW-1:0]    k_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o
);

  logic [WIDTH-1:0] ror_res;

  // Each mode is a single shifter on a word widened by one guard bit, so the
  // bit that falls off the end lands in the guard position and becomes carry.
  // ASR keeps the sign because the working MSB always equals the original MSB.
  always_comb begin
    res_o   = '0;
    carry_o = 1'b0;
    ror_res = WIDTH'({val_i, val_i} >> k_i);
    case (mode_i)
      MODE_LSL: {carry_o, res_o} = {1'b0, val_i} << k_i;
      MODE_LSR: {res_o, carry_o} = {val_i, 1'b0} >> k_i;
      MODE_ASR: {res_o, carry_o} = $signed({val_i, 1'b0}) >>> k_i;
      default: begin
        res_o   = ror_res;
        carry_o = ror_res[WIDTH-1];
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: accepts one operand, walks it STEP bits per
// clock through shift_step, then holds the result until the consumer takes it.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a request; in_ready high
// S_SHIFT | working register being shifted, rem_q positions still to go
// S_DONE  | result/flags registered and presented; out_valid high
module seq_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  localparam int KW  = $clog2(STEP + 1);
  localparam int AW1 = AMT_W + 1;
  // When STEP == WIDTH the truncated STEP_R is never used: rem_q can never
  // reach STEP, so every step is a partial one.
  localparam logic [AW1-1:0]   STEP_A = AW1'(STEP);
  localparam logic [AMT_W-1:0] STEP_R = AMT_W'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       mode_q, mode_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_carry_q, out_carry_d;
  logic             out_zero_q, out_zero_d;

  logic             step_full;
  logic [KW-1:0]    step_k;
  logic [AMT_W-1:0] rem_next;
  logic [WIDTH-1:0] step_res;
  logic             step_carry;

  // Step size for this cycle: a full STEP, or whatever remains if smaller.
  always_comb begin
    step_full = ({1'b0, rem_q} >= STEP_A);
    step_k    = step_full ? KW'(STEP) : KW'(rem_q);
    rem_next  = step_full ? (rem_q - STEP_R) : '0;
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .val_i   (data_q),
    .mode_i  (mode_q),
    .k_i     (step_k),
    .res_o   (step_res),
    .carry_o (step_carry)
  );

  // Next-state and datapath updates; outputs are only rewritten on DONE entry.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    mode_d      = mode_q;
    rem_d       = rem_q;
    out_data_d  = out_data_q;
    out_carry_d = out_carry_q;
    out_zero_d  = out_zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          mode_d = in_mode;
          rem_d  = in_amt;
          if (in_amt == '0) begin
            state_d     = S_DONE;
            out_data_d  = in_data;
            out_carry_d = 1'b0;
            out_zero_d  = (in_data == '0);
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        data_d = step_res;
        rem_d  = rem_next;
        if (rem_next == '0) begin
          state_d     = S_DONE;
          out_data_d  = step_res;
          out_carry_d = step_carry;
          out_zero_d  = (step_res == '0);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      mode_q      <= MODE_ROR;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_carry_q <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_carry_q <= out_carry_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;
  assign out_carry = out_carry_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: a STEP=1 and a STEP=4 instance side by side, each
// request's expected result pushed to a scoreboard at issue, popped at output.
module tb_seq_shifter;
  import shift_pkg::*;

  typedef struct {
    logic [15:0] data;
    logic        carry;
    logic        zero;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [15:0] in_data  [2];
  logic [3:0]  in_amt   [2];
  logic [1:0]  in_mode  [2];
  logic        out_valid[2];
  logic        out_ready[2];
  logic [15:0] out_data [2];
  logic        out_carry[2];
  logic        out_zero [2];

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(16), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_amt(in_amt[0]), .in_mode(in_mode[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_carry(out_carry[0]), .out_zero(out_zero[0])
  );

  seq_shifter #(.WIDTH(16), .STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_amt(in_amt[1]), .in_mode(in_mode[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_carry(out_carry[1]), .out_zero(out_zero[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-at-a-time reference of the shift, independent of STEP.
  function automatic exp_t model(input logic [1:0] m, input logic [15:0] d,
                                 input int a, input int step);
    exp_t        r;
    logic [15:0] v;
    logic        c;
    v = d;
    c = 1'b0;
    for (int i = 0; i < a; i++) begin
      case (m)
        MODE_LSL: begin c = v[15]; v = {v[14:0], 1'b0}; end
        MODE_LSR: begin c = v[0];  v = {1'b0, v[15:1]}; end
        MODE_ASR: begin c = v[0];  v = {v[15], v[15:1]}; end
        default:  begin v = {v[0], v[15:1]}; c = v[15]; end
      endcase
    end
    r.data  = v;
    r.carry = c;
    r.zero  = (v == 16'h0000);
    r.lat   = 1 + (a + step - 1) / step;
    return r;
  endfunction

  // Called just after a falling edge: drive a request and record its expectation.
  task automatic issue(input int s, input logic [1:0] m, input logic [15:0] d, input logic [3:0] a);
    in_valid[s] = 1'b1;
    in_data[s]  = d;
    in_amt[s]   = a;
    in_mode[s]  = m;
    sb_q.push_back(model(m, d, int'(a), (s == 0) ? 1 : 4));
  endtask

  // Accept edge follows; scramble inputs afterwards, wait for the result, compare.
  task automatic collect(input int s, input string tag, output exp_t e);
    int lat;
    @(negedge clk);
    lat = 1;
    in_valid[s] = 1'b0;
    in_data[s]  = 16'($urandom);
    in_amt[s]   = 4'($urandom);
    in_mode[s]  = 2'($urandom);
    while (!out_valid[s] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    e = sb_q.pop_front();
    chk({tag, "_lat"},   lat,          e.lat);
    chk({tag, "_data"},  out_data[s],  e.data);
    chk({tag, "_carry"}, out_carry[s], e.carry);
    chk({tag, "_zero"},  out_zero[s],  e.zero);
  endtask

  task automatic release_out(input int s, input string tag, input exp_t e);
    out_ready[s] = 1'b1;
    @(negedge clk);
    out_ready[s] = 1'b0;
    chk({tag, "_vld_drop"}, out_valid[s], 1'b0);
    chk({tag, "_rdy_back"}, in_ready[s],  1'b1);
    chk({tag, "_data_kept"}, out_data[s], e.data);
  endtask

  task automatic do_op(input int s, input string tag, input logic [1:0] m,
                       input logic [15:0] d, input logic [3:0] a);
    exp_t e;
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready[s], 1'b1);
    issue(s, m, d, a);
    collect(s, tag, e);
    release_out(s, tag, e);
  endtask

  initial begin
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      in_valid[s]  = 1'b0;
      in_data[s]   = 16'h0000;
      in_amt[s]    = 4'h0;
      in_mode[s]   = MODE_ROR;
      out_ready[s] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_rdy",   in_ready[s],  1'b1);
      chk("rst_vld",   out_valid[s], 1'b0);
      chk("rst_data",  out_data[s],  16'h0000);
      chk("rst_carry", out_carry[s], 1'b0);
      chk("rst_zero",  out_zero[s],  1'b0);
    end
    rst_n = 1'b1;

    do_op(0, "lsl1",     MODE_LSL, 16'h8001, 4'd1);
    do_op(0, "asr15",    MODE_ASR, 16'h8000, 4'd15);
    do_op(0, "lsr15",    MODE_LSR, 16'h8000, 4'd15);
    do_op(0, "ror4",     MODE_ROR, 16'h000F, 4'd4);
    do_op(0, "ror0",     MODE_ROR, 16'h1234, 4'd0);
    do_op(0, "lsr1",     MODE_LSR, 16'h8001, 4'd1);
    do_op(0, "asr1",     MODE_ASR, 16'h8001, 4'd1);
    do_op(0, "lsl_zero", MODE_LSL, 16'h00F0, 4'd12);

    // Backpressure: result held 5 cycles while a new request waits on in_valid.
    @(negedge clk);
    chk("bp_rdy", in_ready[0], 1'b1);
    issue(0, MODE_LSL, 16'h00FF, 4'd3);
    collect(0, "bp1", e);
    in_valid[0] = 1'b1;
    in_data[0]  = 16'hABCD;
    in_amt[0]   = 4'd5;
    in_mode[0]  = MODE_ROR;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_vld",   out_valid[0], 1'b1);
      chk("bp_hold_rdy",   in_ready[0],  1'b0);
      chk("bp_hold_data",  out_data[0],  e.data);
      chk("bp_hold_carry", out_carry[0], e.carry);
      chk("bp_hold_zero",  out_zero[0],  e.zero);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    chk("bp_idle_vld",  out_valid[0], 1'b0);
    chk("bp_idle_rdy",  in_ready[0],  1'b1);
    chk("bp_idle_data", out_data[0],  e.data);
    // in_valid is still high, so the coming edge is the accept edge.
    sb_q.push_back(model(MODE_ROR, 16'hABCD, 5, 1));
    collect(0, "bp2", e);
    release_out(0, "bp2", e);

    do_op(1, "s4_lsr9",  MODE_LSR, 16'hFFFF, 4'd9);
    do_op(1, "s4_lsl15", MODE_LSL, 16'h0001, 4'd15);
    do_op(1, "s4_ror0",  MODE_ROR, 16'h00A5, 4'd0);
    do_op(1, "s4_asr8",  MODE_ASR, 16'h9234, 4'd8);

    for (int i = 0; i < 8; i++) begin
      do_op(0, "rnd1", 2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom_range(0, 15)));
      do_op(1, "rnd4", 2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom_range(0, 15)));
    end

    // Leave a nonzero result with carry set so the reset clear is visible.
    do_op(0, "pre_rst", MODE_LSL, 16'hC000, 4'd1);

    // Asynchronous reset three steps into a 12-step ASR.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h9ABC;
    in_amt[0]   = 4'd12;
    in_mode[0]  = MODE_ASR;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld",   out_valid[0], 1'b0);
    chk("arst_data",  out_data[0],  16'h0000);
    chk("arst_carry", out_carry[0], 1'b0);
    chk("arst_zero",  out_zero[0],  1'b0);
    chk("arst_rdy",   in_ready[0],  1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, "post_rst", MODE_LSL, 16'h0003, 4'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
